// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3 slave backed by a register-array memory.
// Independent write and read FSMs, one outstanding burst each, with
// FIXED/INCR/WRAP addressing, byte strobes and SLVERR reporting.
module axi_slave_mem #(
    parameter int DATA_W         = 32,
    parameter int ID_W           = 4,
    parameter int ADDR_W         = 32,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int RD_LAT         = 2
) (
    input  logic                clk,
    input  logic                reset,
    // write address channel
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [ID_W-1:0]     AWID,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [3:0]          AWCACHE,
    input  logic [2:0]          AWPROT,
    input  logic [1:0]          AWLOCK,
    input  logic                AWVALID,
    output logic                AWREADY,
    // write data channel
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    // write response channel
    output logic [1:0]          BRESP,
    output logic [ID_W-1:0]     BID,
    output logic                BVALID,
    input  logic                BREADY,
    // read address channel
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [ID_W-1:0]     ARID,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic [3:0]          ARCACHE,
    input  logic [2:0]          ARPROT,
    input  logic [1:0]          ARLOCK,
    input  logic                ARVALID,
    output logic                ARREADY,
    // read data channel
    output logic [DATA_W-1:0]   RDATA,
    output logic [ID_W-1:0]     RID,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int STRB_W        = DATA_W / 8;
    localparam int BYTE_LOG2     = $clog2(STRB_W);
    localparam int MEM_WORDS     = 1 << MEM_WORDS_LOG2;
    localparam int MEM_ADDR_BITS = MEM_WORDS_LOG2 + BYTE_LOG2;
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [3:0]        LAT_M1 = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    // Address of the beat following addr for the given burst shape.
    function automatic logic [ADDR_W-1:0] beat_next(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [3:0]        len,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] cont;
        logic [ADDR_W-1:0] base;
        step = ONE << size;
        cont = ADDR_W'({1'b0, len} + 5'd1) << size;
        base = addr & ~(cont - ONE);
        case (burst)
            2'b00:   beat_next = addr;
            2'b10:   beat_next = base | ((addr + step) & (cont - ONE));
            default: beat_next = (addr & ~(step - ONE)) + step;
        endcase
    endfunction

    // Request-level errors: oversize beat, reserved burst, illegal wrap length.
    function automatic logic req_bad(
        input logic [2:0] size,
        input logic [3:0] len,
        input logic [1:0] burst
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        req_bad = (int'(size) > BYTE_LOG2) || (burst == 2'b11) ||
                  ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Any address bit above the memory footprint puts the beat out of range.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        out_of_range = (addr[ADDR_W-1:MEM_ADDR_BITS] != '0);
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    // CACHE/PROT/LOCK carry no meaning for this memory.
    logic unused_attr;
    assign unused_attr = ^{AWCACHE, AWPROT, AWLOCK, ARCACHE, ARPROT, ARLOCK};

    // ---------------- write path ----------------
    wstate_t           wstate;
    logic [ID_W-1:0]   awid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        wlen_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              wreq_err_q;
    logic              werr_q;
    logic [4:0]        wbeat_q;

    logic w_fire;
    logic w_in_range;
    logic w_expect_last;
    logic w_beyond;
    logic w_beat_err;
    logic mem_we;

    assign w_fire        = (wstate == W_DATA) && WREADY && WVALID;
    assign w_in_range    = !out_of_range(waddr_q);
    assign w_expect_last = (wbeat_q == {1'b0, wlen_q});
    assign w_beyond      = (wbeat_q > {1'b0, wlen_q});
    assign w_beat_err    = wreq_err_q || !w_in_range || (WID != awid_q) ||
                           (WLAST != w_expect_last) || w_beyond;
    // ID and WLAST errors still write; address/shape errors and overrun beats do not.
    assign mem_we        = w_fire && !reset && !wreq_err_q && w_in_range && !w_beyond;

    // Write FSM: AW capture, beat tracking with error accumulation, B response.
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate  <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            BID     <= '0;
            werr_q  <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        AWREADY    <= 1'b0;
                        WREADY     <= 1'b1;
                        awid_q     <= AWID;
                        waddr_q    <= AWADDR;
                        wlen_q     <= AWLEN;
                        wsize_q    <= AWSIZE;
                        wburst_q   <= AWBURST;
                        wreq_err_q <= req_bad(AWSIZE, AWLEN, AWBURST);
                        werr_q     <= 1'b0;
                        wbeat_q    <= 5'd0;
                        wstate     <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q <= beat_next(waddr_q, wsize_q, wlen_q, wburst_q);
                        if (wbeat_q != 5'd31) begin
                            wbeat_q <= wbeat_q + 5'd1;
                        end
                        werr_q <= werr_q | w_beat_err;
                        if (WLAST) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BRESP  <= (werr_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            BID    <= awid_q;
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Memory array: byte-strobed write on the W handshake edge, contents never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem[waddr_q[MEM_ADDR_BITS-1:BYTE_LOG2]][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path ----------------
    rstate_t           rstate;
    logic [ID_W-1:0]   arid_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [3:0]        rlen_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic              rreq_err_q;
    logic [3:0]        rbeat_q;
    logic [3:0]        rcnt_q;

    logic [DATA_W-1:0] rdata_p1;
    logic [ID_W-1:0]   rid_p1;
    logic [1:0]        rresp_p1;
    logic              rlast_p1;
    logic              rvld_p1;

    logic [ADDR_W-1:0] ld_addr;
    logic [ID_W-1:0]   ld_id;
    logic [3:0]        ld_len;
    logic [2:0]        ld_size;
    logic [1:0]        ld_burst;
    logic              ld_req_err;
    logic [3:0]        ld_beat;
    logic              ld_err;
    logic [DATA_W-1:0] ld_word;
    logic              do_load;

    // Beat source: straight from AR in idle (zero-latency case), else the latched burst.
    always_comb begin
        ld_addr    = raddr_q;
        ld_id      = arid_q;
        ld_len     = rlen_q;
        ld_size    = rsize_q;
        ld_burst   = rburst_q;
        ld_req_err = rreq_err_q;
        ld_beat    = rbeat_q;
        if (rstate == R_IDLE) begin
            ld_addr    = ARADDR;
            ld_id      = ARID;
            ld_len     = ARLEN;
            ld_size    = ARSIZE;
            ld_burst   = ARBURST;
            ld_req_err = req_bad(ARSIZE, ARLEN, ARBURST);
            ld_beat    = 4'd0;
        end
    end

    assign ld_err  = ld_req_err || out_of_range(ld_addr);
    assign ld_word = mem[ld_addr[MEM_ADDR_BITS-1:BYTE_LOG2]];
    assign do_load = ((rstate == R_IDLE) && ARREADY && ARVALID && (RD_LAT == 0)) ||
                     ((rstate == R_WAIT) && (rcnt_q == LAT_M1)) ||
                     ((rstate == R_DATA) && RREADY && !rlast_p1);

    // Read FSM: AR capture, latency count, beat issue held until RREADY.
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate   <= R_IDLE;
            ARREADY  <= 1'b0;
            rvld_p1  <= 1'b0;
            rlast_p1 <= 1'b0;
            rdata_p1 <= '0;
            rresp_p1 <= RESP_OKAY;
            rid_p1   <= '0;
            rcnt_q   <= 4'd0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        ARREADY    <= 1'b0;
                        arid_q     <= ARID;
                        raddr_q    <= ARADDR;
                        rlen_q     <= ARLEN;
                        rsize_q    <= ARSIZE;
                        rburst_q   <= ARBURST;
                        rreq_err_q <= req_bad(ARSIZE, ARLEN, ARBURST);
                        rbeat_q    <= 4'd0;
                        rcnt_q     <= 4'd0;
                        rstate     <= (RD_LAT == 0) ? R_DATA : R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == LAT_M1) begin
                        rstate <= R_DATA;
                    end else begin
                        rcnt_q <= rcnt_q + 4'd1;
                    end
                end
                R_DATA: begin
                    if (RREADY && rlast_p1) begin
                        rvld_p1  <= 1'b0;
                        rlast_p1 <= 1'b0;
                        ARREADY  <= 1'b1;
                        rstate   <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
            // stage p1: registered read beat, memory sampled before any same-edge write
            if (do_load) begin
                rvld_p1  <= 1'b1;
                rdata_p1 <= ld_err ? '0 : ld_word;
                rresp_p1 <= ld_err ? RESP_SLVERR : RESP_OKAY;
                rlast_p1 <= (ld_beat == ld_len);
                rid_p1   <= ld_id;
                raddr_q  <= beat_next(ld_addr, ld_size, ld_len, ld_burst);
                rbeat_q  <= ld_beat + 4'd1;
            end
        end
    end

    assign RDATA  = rdata_p1;
    assign RID    = rid_p1;
    assign RRESP  = rresp_p1;
    assign RLAST  = rlast_p1;
    assign RVALID = rvld_p1;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: single beats, INCR/WRAP bursts, narrow
// writes, SLVERR cases and reset mid-read, with hand-computed expectations.
module tb_axi_slave_mem;

    localparam int LIM = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] AWADDR, ARADDR;
    logic [3:0]  AWID, ARID, AWLEN, ARLEN, AWCACHE, ARCACHE;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WID, WSTRB, BID, RID;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY, RLAST, RVALID, RREADY;

    int checks = 0;
    int errors = 0;

    logic [31:0] wdat [32];
    logic [3:0]  wstb [32];
    logic [31:0] cap_d [16];
    logic [1:0]  cap_r [16];
    logic        cap_l [16];
    logic [3:0]  cap_id [16];
    int          rd_lat;
    int          w_first_wait;
    int          b_wait;
    logic [1:0]  last_bresp;
    logic [3:0]  last_bid;

    always #5 clk = ~clk;

    axi_slave_mem #(
        .DATA_W(32), .ID_W(4), .ADDR_W(32), .MEM_WORDS_LOG2(10), .RD_LAT(2)
    ) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWLOCK(AWLOCK), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WID(WID), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARLOCK(ARLOCK), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full write transaction; called and returns at a negedge.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                             input logic [3:0] wid);
        int t;
        AWADDR = addr; AWID = id; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < LIM) begin @(negedge clk); t++; end
        if (t >= LIM) chk("aw_timeout", t, 0);
        @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            WDATA = wdat[i]; WSTRB = wstb[i]; WID = wid; WLAST = (i == nbeats - 1); WVALID = 1'b1;
            t = 0;
            while (!WREADY && t < LIM) begin @(negedge clk); t++; end
            if (t >= LIM) chk("w_timeout", t, 0);
            if (i == 0) w_first_wait = t;
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        t = 0;
        while (!BVALID && t < LIM) begin @(negedge clk); t++; end
        if (t >= LIM) chk("b_timeout", t, 0);
        b_wait = t;
        last_bresp = BRESP; last_bid = BID;
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input logic [3:0] id);
        wdat[0] = data; wstb[0] = strb;
        axi_write(addr, id, 4'd0, 3'd2, 2'b01, 1, id);
    endtask

    // Full read transaction collecting beats; abort_at>0 asserts reset after that many beats.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            input int abort_at);
        int t, cyc, beats, nexp;
        bit held;
        logic [31:0] hd;
        logic hl;
        ARADDR = addr; ARID = id; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < LIM) begin @(negedge clk); t++; end
        if (t >= LIM) chk("ar_timeout", t, 0);
        nexp = int'(len) + 1; beats = 0; cyc = 0; held = 1'b0; rd_lat = 0; hd = '0; hl = 1'b0;
        while (beats < nexp && cyc < LIM) begin
            @(negedge clk);
            cyc++;
            ARVALID = 1'b0;
            RREADY = toggle ? cyc[0] : 1'b1;
            if (RVALID) begin
                if (rd_lat == 0) rd_lat = cyc;
                if (held) begin
                    chk("r_hold_data", RDATA, hd);
                    chk("r_hold_last", RLAST, hl);
                end
                if (RREADY) begin
                    cap_d[beats] = RDATA; cap_r[beats] = RRESP;
                    cap_l[beats] = RLAST; cap_id[beats] = RID;
                    beats++;
                    held = 1'b0;
                    if (abort_at != 0 && beats == abort_at) begin
                        reset = 1'b1;
                        return;
                    end
                end else begin
                    held = 1'b1; hd = RDATA; hl = RLAST;
                end
            end
        end
        if (beats < nexp) chk("r_timeout", beats, nexp);
        @(negedge clk);
        RREADY = 1'b0;
        chk("r_vld_drop", RVALID, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        AWADDR = '0; AWID = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWCACHE = '0; AWPROT = '0; AWLOCK = '0; AWVALID = 1'b0;
        ARADDR = '0; ARID = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARCACHE = '0; ARPROT = '0; ARLOCK = '0; ARVALID = 1'b0;
        WDATA = '0; WID = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_bresp", BRESP, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("awready_up", AWREADY, 1);
        chk("arready_up", ARREADY, 1);

        // single write then read
        wr1(32'h100, 32'hDEADBEEF, 4'hF, 4'd3);
        chk("t1_wready_lat", w_first_wait, 0);
        chk("t1_bvalid_lat", b_wait, 0);
        chk("t1_bresp", last_bresp, 2'b00);
        chk("t1_bid", last_bid, 4'd3);
        chk("t1_awready_after_b", AWREADY, 1);
        axi_read(32'h100, 4'd5, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t1_rlat", rd_lat, 3);
        chk("t1_rdata", cap_d[0], 32'hDEADBEEF);
        chk("t1_rresp", cap_r[0], 2'b00);
        chk("t1_rlast", cap_l[0], 1);
        chk("t1_rid", cap_id[0], 4'd5);

        // INCR 16 beats, read back with RREADY toggling
        for (int i = 0; i < 16; i++) begin wdat[i] = i; wstb[i] = 4'hF; end
        axi_write(32'h200, 4'd2, 4'd15, 3'd2, 2'b01, 16, 4'd2);
        chk("t2_bresp", last_bresp, 2'b00);
        axi_read(32'h200, 4'd7, 4'd15, 3'd2, 2'b01, 1'b1, 0);
        chk("t2_rlat", rd_lat, 3);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_rdata%0d", i), cap_d[i], i);
            chk($sformatf("t2_rlast%0d", i), cap_l[i], (i == 15));
        end

        // WRAP 4 beats from 0x38 lands on 0x38,0x3C,0x30,0x34
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; end
        axi_write(32'h38, 4'd1, 4'd3, 3'd2, 2'b10, 4, 4'd1);
        chk("t3_bresp", last_bresp, 2'b00);
        axi_read(32'h30, 4'd1, 4'd3, 3'd2, 2'b01, 1'b0, 0);
        chk("t3_w30", cap_d[0], 32'hA2);
        chk("t3_w34", cap_d[1], 32'hA3);
        chk("t3_w38", cap_d[2], 32'hA0);
        chk("t3_w3c", cap_d[3], 32'hA1);
        axi_read(32'h38, 4'd1, 4'd3, 3'd2, 2'b10, 1'b0, 0);
        chk("t3_wrap_rd0", cap_d[0], 32'hA0);
        chk("t3_wrap_rd2", cap_d[2], 32'hA2);
        chk("t3_wrap_last", cap_l[3], 1);

        // narrow byte write over prefill
        wr1(32'h400, 32'h11223344, 4'hF, 4'd0);
        wdat[0] = 32'h0000AB00; wstb[0] = 4'h2;
        axi_write(32'h401, 4'd0, 4'd0, 3'd0, 2'b01, 1, 4'd0);
        chk("t4_bresp", last_bresp, 2'b00);
        axi_read(32'h400, 4'd0, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t4_rdata", cap_d[0], 32'h1122AB44);

        // out-of-range write must not alias onto word 0
        wr1(32'h0, 32'h55AA55AA, 4'hF, 4'd0);
        wr1(32'h1000, 32'hCAFEF00D, 4'hF, 4'd4);
        chk("t5_range_bresp", last_bresp, 2'b10);
        chk("t5_range_bid", last_bid, 4'd4);
        axi_read(32'h0, 4'd0, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t5_range_nowrite", cap_d[0], 32'h55AA55AA);
        // WRAP with LEN=2
        for (int i = 0; i < 3; i++) begin wdat[i] = 32'h77; wstb[i] = 4'hF; end
        axi_write(32'h500, 4'd2, 4'd2, 3'd2, 2'b10, 3, 4'd2);
        chk("t5_wraplen_bresp", last_bresp, 2'b10);
        // WID mismatch still writes a valid address
        wdat[0] = 32'h600D600D; wstb[0] = 4'hF;
        axi_write(32'h600, 4'd1, 4'd0, 3'd2, 2'b01, 1, 4'd2);
        chk("t5_wid_bresp", last_bresp, 2'b10);
        chk("t5_wid_bid", last_bid, 4'd1);
        axi_read(32'h600, 4'd0, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t5_wid_data", cap_d[0], 32'h600D600D);
        // early WLAST on a LEN=3 burst
        for (int i = 0; i < 2; i++) begin wdat[i] = 32'h88; wstb[i] = 4'hF; end
        axi_write(32'h700, 4'd3, 4'd3, 3'd2, 2'b01, 2, 4'd3);
        chk("t5_early_bresp", last_bresp, 2'b10);
        // out-of-range read
        axi_read(32'h1000, 4'd9, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t5_rd_range_data", cap_d[0], 32'h0);
        chk("t5_rd_range_resp", cap_r[0], 2'b10);
        chk("t5_rd_range_last", cap_l[0], 1);

        // reset during an 8-beat read after beat 3
        axi_read(32'h200, 4'd6, 4'd7, 3'd2, 2'b01, 1'b0, 3);
        chk("t6_beat0", cap_d[0], 32'd0);
        chk("t6_beat2", cap_d[2], 32'd2);
        @(negedge clk);
        chk("t6_rvalid_rst", RVALID, 0);
        chk("t6_arready_rst", ARREADY, 0);
        reset = 1'b0;
        RREADY = 1'b0;
        @(negedge clk);
        chk("t6_arready_up", ARREADY, 1);
        chk("t6_rvalid_idle", RVALID, 0);
        axi_read(32'h100, 4'd2, 4'd0, 3'd2, 2'b01, 1'b0, 0);
        chk("t6_after_data", cap_d[0], 32'hDEADBEEF);
        chk("t6_after_resp", cap_r[0], 2'b00);
        chk("t6_after_lat", rd_lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
